// File: rtl/mem_io_responder_if.sv
// mem_io_responder_if: memory bus and UART byte-stream signals between controller side and responder
// Signals:
//   mem_addr, mem_write, r_nw  - byte access request from the memory controller
//   mem_read, io_buffer_full   - read byte and TX flow-control flag back to the controller
//   tx_data, tx_valid, tx_ready - byte stream to the UART transmitter
//   rx_data, rx_valid, rx_ready - byte stream from the UART receiver
// Modports:
//   master - controller/UART environment
//   slave  - the responder
interface mem_io_responder_if;
    logic [31:0] mem_addr;
    logic [7:0]  mem_write;
    logic        r_nw;
    logic [7:0]  mem_read;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    modport master (
        output mem_addr, mem_write, r_nw, tx_ready, rx_data, rx_valid,
        input  mem_read, io_buffer_full, tx_data, tx_valid, rx_ready
    );
    modport slave (
        input  mem_addr, mem_write, r_nw, tx_ready, rx_data, rx_valid,
        output mem_read, io_buffer_full, tx_data, tx_valid, rx_ready
    );
endinterface

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte-serial bus responder serving a synchronous RAM and a UART/halt I/O window
// Ports:
//   clk_in      - clock
//   rst_n_in    - asynchronous active-low reset
//   rdy_in      - global enable; low freezes all bus-side state (TX drain keeps running)
//   bus         - slave side of mem_io_responder_if (memory bus, UART TX and RX streams)
//   sim_halt    - sticky flag set by a write to 0x30004
//   tx_overflow - sticky flag set when a TX byte is dropped on a full FIFO
module mem_io_responder #(
    parameter int ADDR_WIDTH     = 17,
    parameter int FIFO_DEPTH_LOG = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    mem_io_responder_if.slave bus,
    output logic              sim_halt,
    output logic              tx_overflow
);
    localparam int DEPTH     = 1 << FIFO_DEPTH_LOG;
    localparam int RAM_BYTES = 1 << ADDR_WIDTH;
    typedef logic [FIFO_DEPTH_LOG-1:0] ptr_t;
    typedef logic [FIFO_DEPTH_LOG:0]   cnt_t;
    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    // Two slots of slack absorb a controller write already in flight when the flag rises
    localparam cnt_t CNT_NEAR = cnt_t'(DEPTH - 2);

    logic                  io_sel, io_data, io_stat;
    logic                  rd, wr, ram_we, ram_rd;
    logic                  push_req, push_ok, pop, full, tx_valid;
    logic [ADDR_WIDTH-1:0] idx;
    logic [7:0]            io_rdata;
    logic [7:0]            ram_q [RAM_BYTES];
    logic [7:0]            ram_rdata_q;
    logic [7:0]            fifo_q [DEPTH];
    ptr_t                  head_q, head_d, tail_q, tail_d;
    cnt_t                  count_q, count_d;
    logic                  rd_ram_q, rd_ram_d;
    logic [7:0]            hold_q, hold_d;
    logic                  ibf_q, ibf_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  halt_q, halt_d;
    logic                  ovf_q, ovf_d;
    logic                  unused_addr;

    assign unused_addr = ^bus.mem_addr;
    assign tx_valid    = count_q != '0;

    always_comb begin
        io_sel     = bus.mem_addr[17:16] == 2'b11;
        io_data    = io_sel && bus.mem_addr[15:0] == 16'h0000;
        io_stat    = io_sel && bus.mem_addr[15:0] == 16'h0004;
        idx        = bus.mem_addr[ADDR_WIDTH-1:0];
        rd         = rdy_in && bus.r_nw;
        wr         = rdy_in && !bus.r_nw;
        ram_we     = wr && !io_sel;
        ram_rd     = rd && !io_sel;
        push_req   = wr && io_data;
        pop        = tx_valid && bus.tx_ready;
        full       = count_q == CNT_FULL;
        // A simultaneous pop frees a slot, so a push onto a full FIFO still lands
        push_ok    = push_req && (!full || pop);
        io_rdata   = io_data ? (bus.rx_valid ? bus.rx_data : 8'h00) :
                     io_stat ? {6'b0, ibf_q, tx_valid} : 8'h00;
        head_d     = pop ? head_q + ptr_t'(1) : head_q;
        tail_d     = push_ok ? tail_q + ptr_t'(1) : tail_q;
        count_d    = (push_ok && !pop) ? count_q + cnt_t'(1) :
                     (pop && !push_ok) ? count_q - cnt_t'(1) : count_q;
        ibf_d      = count_d >= CNT_NEAR;
        ovf_d      = ovf_q || (push_req && !push_ok);
        halt_d     = halt_q || (wr && io_stat);
        rx_ready_d = rd && io_data && bus.rx_valid;
        // mem_read is sourced from the RAM output register after RAM reads and from
        // hold_q after I/O reads; both hold when no read happens
        rd_ram_d   = rd ? !io_sel : rd_ram_q;
        hold_d     = (rd && io_sel) ? io_rdata : hold_q;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rd_ram_q   <= 1'b0;
            hold_q     <= 8'h00;
            ibf_q      <= 1'b0;
            rx_ready_q <= 1'b0;
            halt_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rd_ram_q   <= rd_ram_d;
            hold_q     <= hold_d;
            ibf_q      <= ibf_d;
            rx_ready_q <= rx_ready_d;
            halt_q     <= halt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage arrays carry no reset so they map onto block RAM
    always_ff @(posedge clk_in) begin
        if (ram_we) ram_q[idx] <= bus.mem_write;
        if (ram_rd) ram_rdata_q <= ram_q[idx];
        if (push_ok) fifo_q[tail_q] <= bus.mem_write;
    end

    assign bus.mem_read       = rd_ram_q ? ram_rdata_q : hold_q;
    assign bus.io_buffer_full = ibf_q;
    assign bus.tx_valid       = tx_valid;
    assign bus.tx_data        = fifo_q[head_q];
    assign bus.rx_ready       = rx_ready_q;
    assign sim_halt           = halt_q;
    assign tx_overflow        = ovf_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: scoreboard bench for mem_io_responder (RAM, TX FIFO, RX, status, halt, reset)
module tb_mem_io_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b0;
    logic sim_halt, tx_overflow;
    logic rd_issued = 1'b0;
    logic [7:0] rd_q[$];
    logic [7:0] tx_q[$];
    int checks = 0;
    int errors = 0;

    mem_io_responder_if bus();

    mem_io_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH_LOG(4)) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .rdy_in(rdy),
        .bus(bus),
        .sim_halt(sim_halt),
        .tx_overflow(tx_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_issued <= rst_n && rdy && bus.r_nw;

    always @(negedge clk) begin
        if (rd_issued) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got 0x%0h with no expected read", bus.mem_read);
            end else chk("mem_read", {24'h0, bus.mem_read}, {24'h0, rd_q.pop_front()});
        end
        if (rst_n && bus.tx_valid && bus.tx_ready) begin
            if (tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got 0x%0h with no expected byte", bus.tx_data);
            end else chk("tx_data", {24'h0, bus.tx_data}, {24'h0, tx_q.pop_front()});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        rdy = 1'b1;
        bus.r_nw = 1'b0;
        bus.mem_addr = a;
        bus.mem_write = d;
        cyc();
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] e);
        rdy = 1'b1;
        bus.r_nw = 1'b1;
        bus.mem_addr = a;
        rd_q.push_back(e);
        cyc();
    endtask

    task automatic push(input logic [7:0] d);
        tx_q.push_back(d);
        wr(32'h30000, d);
    endtask

    task automatic idle();
        rdy = 1'b0;
        bus.r_nw = 1'b1;
        cyc();
    endtask

    initial begin
        int n;
        bus.mem_addr = '0;
        bus.mem_write = '0;
        bus.r_nw = 1'b1;
        bus.tx_ready = 1'b0;
        bus.rx_data = '0;
        bus.rx_valid = 1'b0;
        repeat (2) cyc();
        chk("rst_mem_read", {24'h0, bus.mem_read}, 32'h0);
        chk("rst_ibf", {31'h0, bus.io_buffer_full}, 32'h0);
        chk("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
        chk("rst_rx_ready", {31'h0, bus.rx_ready}, 32'h0);
        chk("rst_sim_halt", {31'h0, sim_halt}, 32'h0);
        chk("rst_tx_overflow", {31'h0, tx_overflow}, 32'h0);
        rst_n = 1'b1;
        cyc();
        wr(32'h10, 8'hA5);
        chk("hold_on_write", {24'h0, bus.mem_read}, 32'h0);
        rd(32'h10, 8'hA5);
        for (int i = 0; i < 4; i++) wr(32'h100 + 32'(i), 8'((i + 1) * 17));
        for (int i = 0; i < 4; i++) rd(32'h100 + 32'(i), 8'((i + 1) * 17));
        rd(32'h20100, 8'h11);
        idle();
        for (int i = 0; i < 14; i++) begin
            push(8'h80 + 8'(i));
            if (i == 12) chk("ibf_count13", {31'h0, bus.io_buffer_full}, 32'h0);
        end
        chk("ibf_count14", {31'h0, bus.io_buffer_full}, 32'h1);
        push(8'h8E);
        push(8'h8F);
        chk("ovf_at_16", {31'h0, tx_overflow}, 32'h0);
        chk("tx_valid_full", {31'h0, bus.tx_valid}, 32'h1);
        bus.tx_ready = 1'b1;
        push(8'hC0);
        bus.tx_ready = 1'b0;
        chk("ovf_push_pop_full", {31'h0, tx_overflow}, 32'h0);
        wr(32'h30000, 8'hEE);
        chk("ovf_set", {31'h0, tx_overflow}, 32'h1);
        rd(32'h30004, 8'h03);
        idle();
        bus.tx_ready = 1'b1;
        cyc();
        cyc();
        chk("drain_ibf_14", {31'h0, bus.io_buffer_full}, 32'h1);
        cyc();
        chk("drain_ibf_13", {31'h0, bus.io_buffer_full}, 32'h0);
        n = 0;
        while (bus.tx_valid && n < 40) begin
            cyc();
            n++;
        end
        chk("drain_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
        chk("drain_all_seen", 32'(tx_q.size()), 32'h0);
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'h5A;
        rd(32'h30000, 8'h5A);
        bus.rx_valid = 1'b0;
        chk("rx_ready_pulse", {31'h0, bus.rx_ready}, 32'h1);
        idle();
        chk("rx_ready_one_cycle", {31'h0, bus.rx_ready}, 32'h0);
        rd(32'h30000, 8'h00);
        chk("rx_ready_none", {31'h0, bus.rx_ready}, 32'h0);
        push(8'hD1);
        push(8'hD2);
        push(8'hD3);
        rd(32'h30004, 8'h01);
        rd(32'h30008, 8'h00);
        rdy = 1'b0;
        bus.r_nw = 1'b0;
        bus.mem_addr = 32'h10;
        bus.mem_write = 8'h5F;
        cyc();
        rd(32'h10, 8'hA5);
        wr(32'h30004, 8'h00);
        chk("halt_set", {31'h0, sim_halt}, 32'h1);
        idle();
        idle();
        chk("halt_sticky", {31'h0, sim_halt}, 32'h1);
        chk("hold_idle", {24'h0, bus.mem_read}, 32'hA5);
        bus.tx_ready = 1'b1;
        idle();
        #2;
        rst_n = 1'b0;
        tx_q.delete();
        #1;
        chk("async_rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
        chk("async_rst_mem_read", {24'h0, bus.mem_read}, 32'h0);
        chk("async_rst_sim_halt", {31'h0, sim_halt}, 32'h0);
        chk("async_rst_overflow", {31'h0, tx_overflow}, 32'h0);
        chk("async_rst_ibf", {31'h0, bus.io_buffer_full}, 32'h0);
        cyc();
        rst_n = 1'b1;
        bus.tx_ready = 1'b0;
        cyc();
        chk("post_rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
        chk("reads_all_seen", 32'(rd_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Responder end of the byte-serial memory bus that the memory controller drives through mem_addr, mem_write and r_nw.
- Serves one byte per cycle from a synchronous RAM, with one cycle of read latency.
- Maps the 0x30000 window to I/O: UART TX through a FIFO, UART RX, a status register and a simulation-halt register.
- Drives io_buffer_full back to the controller as flow control.

Parameters:
ADDR_WIDTH, 17, RAM byte-address width (RAM size is 2^ADDR_WIDTH bytes).
FIFO_DEPTH_LOG, 4, log2 of the TX FIFO depth (default depth 16).

Ports:
clk_in  input  1  clock
rst_n_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global enable; low freezes all bus-side state
mem_addr  input  32  byte address from the controller
mem_write  input  8  write byte from the controller
r_nw  input  1  1 = read, 0 = write
mem_read  output  8  read byte, registered
io_buffer_full  output  1  TX FIFO near-full, registered
tx_data  output  8  byte to the UART transmitter
tx_valid  output  1  tx_data valid
tx_ready  input  1  UART accepts tx_data
rx_data  input  8  byte from the UART receiver
rx_valid  input  1  rx_data valid
rx_ready  output  1  one-cycle pop strobe to the receiver
sim_halt  output  1  sticky; set by a write to 0x30004
tx_overflow  output  1  sticky; set when a TX write is dropped

Behaviour:
- Reset (async assert, sync release): mem_read=0, io_buffer_full=0, FIFO empty (tx_valid=0), rx_ready=0, sim_halt=0, tx_overflow=0. RAM contents are not reset.
- Decode: io_sel = (mem_addr[17:16]==2'b11). If io_sel=0, RAM index = mem_addr[ADDR_WIDTH-1:0]; upper address bits are ignored.
- Bus transactions occur only when rdy_in=1. With rdy_in=0 there is no RAM write, no FIFO push, no RX pop, and mem_read holds. The TX drain side runs regardless of rdy_in.
- RAM read (r_nw=1, io_sel=0): mem_read <= RAM[idx] at the clock edge, so data is valid the cycle after the address is presented.
- RAM write (r_nw=0, io_sel=0): RAM[idx] <= mem_write; mem_read is unchanged. A read of the same address in the next cycle returns the new byte.
- mem_read updates only on read cycles; it holds its value across writes and idle cycles.
- I/O reads at cycle N, result in mem_read at N+1:
  - 0x30000 with rx_valid=1: returns rx_data; rx_ready=1 for exactly cycle N+1.
  - 0x30000 with rx_valid=0: returns 0x00; no strobe.
  - 0x30004: returns {6'b0, io_buffer_full, tx_valid}.
  - Any other I/O address: returns 0x00.
- I/O writes:
  - 0x30000: push mem_write into the TX FIFO.
  - 0x30004: set sim_halt.
  - Any other I/O address: ignored.
- TX FIFO: circular buffer with a count of 0..DEPTH; pointers wrap modulo DEPTH.
  - tx_valid = (count!=0); tx_data = head entry, shown combinationally.
  - Pop when tx_valid && tx_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance. This is also legal when full: the pop frees the slot.
  - Push when count==DEPTH with no simultaneous pop: byte dropped, tx_overflow set, pointers unchanged.
- io_buffer_full is a register updated every cycle from the next count: high iff next_count >= DEPTH-2. The two slots of slack cover a controller request already in flight when the flag rises.
- Does not check transaction framing; each cycle with rdy_in=1 is treated as an independent byte access. A write cycle with r_nw=0 at a RAM address always writes, so the controller must never issue spurious writes.

Test Plan:
- Write 0xA5 to RAM 0x00010, then read 0x00010 on the next cycle -> mem_read=0xA5 one cycle after the read address; mem_read unchanged during the write cycle.
- Write 0x11,0x22,0x33,0x44 to 0x100..0x103, then read 0x100..0x103 on 4 consecutive cycles -> mem_read = 0x11,0x22,0x33,0x44 on cycles 1-4 after the first read; read address 0x20100 aliases to 0x00100 -> 0x11.
- tx_ready=0, push 14 bytes to 0x30000 -> io_buffer_full=1 the cycle after the 14th push; push 2 more -> count 16, no overflow; push a 17th -> tx_overflow=1 and the byte is lost. Then raise tx_ready -> 16 bytes drain in order, tx_valid falls after the last, io_buffer_full falls when count<14.
- Full FIFO with tx_ready=1 and a push in the same cycle -> count stays 16, tx_overflow stays 0, FIFO order preserved.
- rx_valid=1, rx_data=0x5A, read 0x30000 -> mem_read=0x5A and a one-cycle rx_ready pulse; with rx_valid=0 -> mem_read=0x00, no pulse. Read 0x30004 with 3 bytes queued -> 0x01.
- rdy_in=0 while presenting a RAM write -> RAM unchanged. Write 0x30004 -> sim_halt=1 and stays set. Assert rst_n_in low mid-drain -> outputs clear immediately, without waiting for a clock edge.
